// File: rtl/rhs_spi_responder_if.sv
// SPI link bundle between the team's SPI master and the RHS2116 responder model.
// master drives cs/sclk/mosi; slave (the responder) drives miso.
interface rhs_spi_responder_if;
    logic cs;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output cs, output sclk, output mosi, input miso);
    modport slave  (input cs, input sclk, input mosi, output miso);
endinterface

// File: rtl/rhs_spi_responder.sv
// Device-side model of the RHS2116 SPI link (CPOL=0, CPHA=0) with a 16x16 register file.
// Optional macro RHS_RESP_INPUT_SYNC_EN inserts a 2-FF synchronizer on cs/sclk/mosi.
module rhs_spi_responder #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_BITS   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    rhs_spi_responder_if.slave     spi,
    input  logic [WORD_LENGTH-1:0] sample_data,
    output logic [WORD_LENGTH-1:0] cmd_word,
    output logic                   cmd_v,
    output logic                   frame_err
);
    localparam int REGS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT, S_COMMIT} state_t;

    logic cs_now;
    logic sclk_now;
    logic mosi_now;

`ifdef RHS_RESP_INPUT_SYNC_EN
    logic [1:0] cs_sync_q, cs_sync_d;
    logic [1:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    always_comb begin
        cs_sync_d   = {cs_sync_q[0], spi.cs};
        sclk_sync_d = {sclk_sync_q[0], spi.sclk};
        mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // cs starts low so IDLE only leaves once the pin is really high
            cs_sync_q   <= 2'b00;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign cs_now   = cs_sync_q[1];
    assign sclk_now = sclk_sync_q[1];
    assign mosi_now = mosi_sync_q[1];
`else
    assign cs_now   = spi.cs;
    assign sclk_now = spi.sclk;
    assign mosi_now = spi.mosi;
`endif

    logic cs_prev_q, cs_prev_d;
    logic sclk_prev_q, sclk_prev_d;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    always_comb begin
        cs_prev_d   = cs_now;
        sclk_prev_d = sclk_now;
        cs_rise     = cs_now & ~cs_prev_q;
        cs_fall     = ~cs_now & cs_prev_q;
        sclk_rise   = sclk_now & ~sclk_prev_q;
        sclk_fall   = ~sclk_now & sclk_prev_q;
    end

    state_t                   state_q, state_d;
    logic [5:0]               bit_cnt_q, bit_cnt_d;
    logic [WORD_LENGTH-1:0]   rx_q, rx_d;
    logic [WORD_LENGTH-1:0]   tx_q, tx_d;
    logic [WORD_LENGTH-1:0]   tx_hold_q, tx_hold_d;
    logic [WORD_LENGTH-1:0]   resp_q, resp_d;
    logic [WORD_LENGTH-1:0]   cmd_word_q, cmd_word_d;
    logic                     cmd_v_q, cmd_v_d;
    logic                     frame_err_q, frame_err_d;

    logic [1:0]               opcode;
    logic [ADDR_BITS-1:0]     addr;
    logic [WORD_LENGTH-1:0]   resp_new;
    logic                     reg_we;
    logic [15:0]              reg_rd [REGS];

    // Register file: one flop word per entry, written only from COMMIT
    for (genvar gi = 0; gi < REGS; gi++) begin : g_regfile
        logic [15:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if (reg_we && (addr == ADDR_BITS'(gi))) begin
                entry_d = rx_q[15:0];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                entry_q <= 16'h0000;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign reg_rd[gi] = entry_q;
    end

    always_comb begin
        opcode = rx_q[WORD_LENGTH-1:WORD_LENGTH-2];
        addr   = rx_q[16 +: ADDR_BITS];
        unique case (opcode)
            2'b10:   resp_new = {{(WORD_LENGTH-16){1'b1}}, rx_q[15:0]};
            2'b11:   resp_new = {{(WORD_LENGTH-16){1'b0}}, reg_rd[addr]};
            2'b00:   resp_new = sample_data;
            default: resp_new = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        tx_hold_d   = tx_hold_q;
        resp_d      = resp_q;
        cmd_word_d  = cmd_word_q;
        cmd_v_d     = 1'b0;
        frame_err_d = 1'b0;
        reg_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cs_now) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (cs_fall) begin
                    bit_cnt_d = 6'd0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q == 6'(WORD_LENGTH)) begin
                        state_d = S_COMMIT;
                    end else begin
                        // Aborted frame: undo the partial shift so the next frame replays it
                        frame_err_d = 1'b1;
                        tx_d        = tx_hold_q;
                        state_d     = S_ARMED;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[WORD_LENGTH-2:0], mosi_now};
                        if (bit_cnt_q != 6'd63) begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[WORD_LENGTH-2:0], 1'b0};
                    end
                end
            end
            S_COMMIT: begin
                cmd_v_d    = 1'b1;
                cmd_word_d = rx_q;
                resp_d     = resp_new;
                tx_d       = resp_q;
                tx_hold_d  = resp_q;
                reg_we     = (opcode == 2'b10);
                state_d    = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 6'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            tx_hold_q   <= '0;
            resp_q      <= '0;
            cmd_word_q  <= '0;
            cmd_v_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tx_hold_q   <= tx_hold_d;
            resp_q      <= resp_d;
            cmd_word_q  <= cmd_word_d;
            cmd_v_q     <= cmd_v_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi.miso  = cs_now ? 1'b0 : tx_q[WORD_LENGTH-1];
    assign cmd_word  = cmd_word_q;
    assign cmd_v     = cmd_v_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_rhs_spi_responder.sv
// Scoreboard bench for rhs_spi_responder: the driver acts as SPI master and queues
// expected miso words / cmd_word values; independent monitors pop and compare.
module tb_rhs_spi_responder;
    localparam int HALF = 4;   // sclk half period in clk cycles (ratio 8)
    localparam int GAP  = 6;   // cs-high clk cycles between frames

    logic        clk;
    logic        reset;
    logic [31:0] sample_data;
    logic [31:0] cmd_word;
    logic        cmd_v;
    logic        frame_err;

    rhs_spi_responder_if spi_if ();

    rhs_spi_responder #(.WORD_LENGTH(32), .ADDR_BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (spi_if.slave),
        .sample_data (sample_data),
        .cmd_word    (cmd_word),
        .cmd_v       (cmd_v),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        bit          chk;
    } mexp_t;

    mexp_t       mq [$];
    logic [31:0] cq [$];
    int          ferr_pend   = 0;
    int          n_cmd_push  = 0;
    int          n_cmdv_seen = 0;
    int          n_ferr_push = 0;
    int          n_ferr_seen = 0;
    int          checks      = 0;
    int          errors      = 0;

    // Reference model of the chip's register file and two-deep response pipeline
    logic [15:0] rf_m [16];
    logic [31:0] resp_m;
    logic [31:0] tx_m;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
        resp_m = 32'h0;
        tx_m   = 32'h0;
    endfunction

    // Advance the model by one committed frame; returns the miso word of that frame
    function automatic logic [31:0] model_step(input logic [31:0] c);
        logic [31:0] r;
        logic [31:0] out;
        case (c[31:30])
            2'b10:   r = {16'hFFFF, c[15:0]};
            2'b11:   r = {16'h0000, rf_m[c[19:16]]};
            2'b00:   r = sample_data;
            default: r = 32'h0;
        endcase
        out    = tx_m;
        tx_m   = resp_m;
        resp_m = r;
        if (c[31:30] == 2'b10) rf_m[c[19:16]] = c[15:0];
        return out;
    endfunction

    // kind: 0 normal, 1 aborted (nbits != 32), 2 reset asserted at bit rst_bit
    task automatic do_frame(input logic [31:0] cmd, input int nbits, input int kind,
                            input int rst_bit, input bit hand, input logic [31:0] hand_exp);
        mexp_t e;
        logic [31:0] mexp;
        if (kind == 0) begin
            mexp = model_step(cmd);
            e.w   = hand ? hand_exp : mexp;
            e.chk = 1'b1;
            cq.push_back(cmd);
            n_cmd_push++;
        end else begin
            e.w   = 32'h0;
            e.chk = 1'b0;
            if (kind == 1) begin
                ferr_pend++;
                n_ferr_push++;
            end
        end
        mq.push_back(e);
        $display("frame cmd=%h bits=%0d kind=%0d expect_miso=%h", cmd, nbits, kind, e.w);

        @(negedge clk);
        spi_if.cs = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            spi_if.mosi = (b < 32) ? cmd[31-b] : 1'b0;
            if (kind == 2 && b == rst_bit) begin
                reset = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b1;
                model_reset();
            end
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_if.sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_if.cs = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    // miso monitor: assemble the word shifted out in each frame
    initial begin
        int          nb;
        logic [31:0] word;
        mexp_t       e;
        forever begin
            @(negedge spi_if.cs);
            nb   = 0;
            word = 32'h0;
            forever begin
                @(posedge spi_if.sclk or posedge spi_if.cs);
                if (spi_if.cs) break;
                word = {word[30:0], spi_if.miso};
                nb++;
            end
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL miso_unexpected_frame: actual=%h required=no frame", word);
            end else begin
                e = mq.pop_front();
                if (e.chk) begin
                    chk("miso_word", word, e.w);
                    $display("miso frame bits=%0d got=%h want=%h", nb, word, e.w);
                end
            end
        end
    end

    // cmd_v / frame_err monitor
    always @(negedge clk) begin
        logic [31:0] exp_cmd;
        if (reset && cmd_v) begin
            n_cmdv_seen++;
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_v_unexpected: actual cmd_word=%h required=no pulse", cmd_word);
            end else begin
                exp_cmd = cq.pop_front();
                chk("cmd_word", cmd_word, exp_cmd);
            end
        end
        if (reset && frame_err) begin
            n_ferr_seen++;
            checks++;
            if (ferr_pend == 0) begin
                errors++;
                $display("FAIL frame_err_unexpected: actual=1 required=0");
            end else begin
                ferr_pend--;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c;
        spi_if.cs   = 1'b1;
        spi_if.sclk = 1'b0;
        spi_if.mosi = 1'b0;
        sample_data = 32'h0;
        reset       = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_miso", {31'b0, spi_if.miso}, 32'h0);
        chk("reset_cmd_word", cmd_word, 32'h0);
        chk("reset_cmd_v", {31'b0, cmd_v}, 32'h0);
        chk("reset_frame_err", {31'b0, frame_err}, 32'h0);

        // Write then read r3
        do_frame(32'h8003_1234, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'hC003_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'hFFFF_1234);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_1234);

        // CONVERT returns sample_data two frames later
        sample_data = 32'hA5A5_5A5A;
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'hA5A5_5A5A);

        // Short frame does not disturb the pipeline
        do_frame(32'h8007_7777, 20, 1, 0, 1'b0, 32'h0);
        do_frame(32'h8005_0BEE, 32, 0, 0, 1'b1, 32'hA5A5_5A5A);
        do_frame(32'hC005_0000, 32, 0, 0, 1'b1, 32'hA5A5_5A5A);
        do_frame(32'h4000_0000, 32, 0, 0, 1'b1, 32'hFFFF_0BEE);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_0BEE);

        // Long frame leaves r5 untouched
        do_frame(32'h8005_DEAD, 33, 1, 0, 1'b0, 32'h0);
        do_frame(32'hC005_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'hA5A5_5A5A);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_0BEE);

        // Reset mid-frame, released with cs still low
        do_frame(32'h8003_FFFF, 32, 2, 12, 1'b0, 32'h0);
        do_frame(32'hC003_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'h0000_0000);
        do_frame(32'h0000_0000, 32, 0, 0, 1'b1, 32'hA5A5_5A5A);

        // Random WRITE/READ traffic against the model
        for (int i = 0; i < 100; i++) begin
            c = {($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10, 10'h000,
                 4'($urandom_range(0, 15)), 16'($urandom)};
            do_frame(c, 32, 0, 0, 1'b0, 32'h0);
        end

        repeat (20) @(negedge clk);
        chk("cmd_v_total", 32'(n_cmdv_seen), 32'(n_cmd_push));
        chk("frame_err_total", 32'(n_ferr_seen), 32'(n_ferr_push));
        chk("cmd_queue_left", 32'(cq.size()), 32'h0);
        chk("miso_queue_left", 32'(mq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
